// File: rtl/sel_pkg.sv
// rtl/sel_pkg.sv - shared constants, state type and helpers for the slot-select scan sequencer
package sel_pkg;

  localparam int unsigned NUM_SLOTS = 32;
  localparam logic [7:0]  BASE      = 8'h80;
  localparam logic [7:0]  IDLE_CNT  = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    FIN   = 2'd2
  } sel_state_t;

  // Lowest set bit of a slot mask, returned as {found, index}.
  function automatic logic [5:0] find_first(input logic [NUM_SLOTS-1:0] m);
    logic [5:0] r;
    r = 6'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (m[i]) r = {1'b1, 5'(i)};
    end
    return r;
  endfunction

  // Slot index to decoder count; BASE has no bits in [4:0], so no carry occurs.
  function automatic logic [7:0] slot_count(input logic [4:0] idx);
    return BASE + {3'b000, idx};
  endfunction

endpackage

// File: rtl/sel_window_dec.sv
// rtl/sel_window_dec.sv - 8-bit count to 32-way one-hot select for the 0x80..0x9F window
module sel_window_dec
  import sel_pkg::*;
(
  input  logic [7:0]           count,
  output logic [NUM_SLOTS-1:0] select
);

  // Only counts with top bits 3'b100 land in the window; everything else selects nothing.
  always_comb begin
    select = '0;
    if (count[7:5] == 3'b100) select[count[4:0]] = 1'b1;
  end

endmodule

// File: rtl/sel_scan_ctrl.sv
// rtl/sel_scan_ctrl.sv - steps the decoder count through enabled slots with ack handshake and timeout
module sel_scan_ctrl
  import sel_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_SLOTS-1:0] slot_mask,
  input  logic                 slot_ack,
  output logic [7:0]           count,
  output logic [NUM_SLOTS-1:0] select,
  output logic                 slot_valid,
  output logic [4:0]           cur_slot,
  output logic                 busy,
  output logic                 done,
  output logic                 tmo_err
);

  sel_state_t           state_q, state_d;
  logic [7:0]           count_q, count_d;
  logic [4:0]           cur_q, cur_d;
  logic [NUM_SLOTS-1:0] mask_q, mask_d;
  logic [7:0]           tmo_q, tmo_d;
  logic                 err_q, err_d;

  logic [5:0]           first_hit;
  logic [5:0]           next_hit;
  logic [NUM_SLOTS-1:0] above_cur;
  logic                 tmo_hit;

  // Slots strictly above the one being served; shifting twice lets slot 31 clear everything.
  assign above_cur = mask_q & ((32'hFFFF_FFFF << cur_q) << 1);
  assign first_hit = find_first(slot_mask);
  assign next_hit  = find_first(above_cur);
  // This is the TIMEOUT-th cycle the slot has gone unanswered.
  assign tmo_hit   = (tmo_q == 8'(TIMEOUT - 1));

  // State and datapath registers; reset returns to an idle decoder with the error cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= IDLE_CNT;
      cur_q   <= 5'd0;
      mask_q  <= '0;
      tmo_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cur_q   <= cur_d;
      mask_q  <= mask_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: abort wins over everything, then start/ack/timeout by state.
  always_comb begin
    state_d = state_q;
    count_d = IDLE_CNT;
    cur_d   = cur_q;
    mask_d  = mask_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mask_d = slot_mask;
            err_d  = 1'b0;
            if (first_hit[5]) begin
              state_d = SERVE;
              cur_d   = first_hit[4:0];
              count_d = slot_count(first_hit[4:0]);
              tmo_d   = 8'd0;
            end else begin
              state_d = FIN;
            end
          end
        end
        SERVE: begin
          count_d = count_q;
          if (slot_ack || tmo_hit) begin
            if (!slot_ack) err_d = 1'b1;
            if (next_hit[5]) begin
              cur_d   = next_hit[4:0];
              count_d = slot_count(next_hit[4:0]);
              tmo_d   = 8'd0;
            end else begin
              state_d = FIN;
              count_d = IDLE_CNT;
            end
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
        FIN: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  sel_window_dec u_dec (
    .count  (count_q),
    .select (select)
  );

  assign count      = count_q;
  assign cur_slot   = cur_q;
  assign slot_valid = (state_q == SERVE);
  assign busy       = (state_q == SERVE);
  assign done       = (state_q == FIN);
  assign tmo_err    = err_q;

endmodule

// File: tb/tb_sel_scan_ctrl.sv
// tb/tb_sel_scan_ctrl.sv - self-checking bench for sel_scan_ctrl
module tb_sel_scan_ctrl;

  localparam int TMO = 15;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] slot_mask;
  logic        slot_ack;
  logic [7:0]  count;
  logic [31:0] select;
  logic        slot_valid;
  logic [4:0]  cur_slot;
  logic        busy;
  logic        done;
  logic        tmo_err;

  int vectors;
  int miscompares;
  bit chk_on;

  sel_scan_ctrl #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .slot_mask  (slot_mask),
    .slot_ack   (slot_ack),
    .count      (count),
    .select     (select),
    .slot_valid (slot_valid),
    .cur_slot   (cur_slot),
    .busy       (busy),
    .done       (done),
    .tmo_err    (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: scan is either active on a slot, in its one-cycle finish, or idle.
  bit          m_act, m_fin, m_err;
  int          m_slot, m_wait;
  logic [31:0] m_mask;

  function automatic int next_from(input logic [31:0] m, input int from);
    for (int i = from; i < 32; i++) if (m[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    int n;
    if (rst) begin
      m_act = 0; m_fin = 0; m_err = 0; m_slot = 0; m_wait = 0; m_mask = '0;
    end else if (abort) begin
      m_act = 0; m_fin = 0;
    end else if (m_fin) begin
      m_fin = 0;
    end else if (m_act) begin
      m_wait = m_wait + 1;
      if (slot_ack || m_wait == TMO) begin
        if (!slot_ack) m_err = 1;
        n = next_from(m_mask, m_slot + 1);
        if (n < 0) begin
          m_act = 0; m_fin = 1;
        end else begin
          m_slot = n; m_wait = 0;
        end
      end
    end else if (start) begin
      m_err  = 0;
      m_mask = slot_mask;
      n = next_from(slot_mask, 0);
      if (n < 0) m_fin = 1;
      else begin
        m_act = 1; m_slot = n; m_wait = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("m_count",  {24'd0, count},       m_act ? 32'(128 + m_slot) : 32'd0);
      cmp("m_select", select,               m_act ? (32'd1 << m_slot) : 32'd0);
      cmp("m_valid",  {31'd0, slot_valid},  {31'd0, m_act});
      cmp("m_busy",   {31'd0, busy},        {31'd0, m_act});
      cmp("m_done",   {31'd0, done},        {31'd0, m_fin});
      cmp("m_tmo",    {31'd0, tmo_err},     {31'd0, m_err});
      if (m_act) cmp("m_slot", {27'd0, cur_slot}, 32'(m_slot));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int held;
    bit seen_done;
    int done_cnt;
    bit saw_busy;
    vectors = 0; miscompares = 0; chk_on = 0;
    rst = 1; start = 0; abort = 0; slot_mask = '0; slot_ack = 0;

    // 1: reset values
    repeat (3) @(negedge clk);
    chk_on = 1;
    cmp("t1_count", {24'd0, count}, 32'h00);
    cmp("t1_select", select, 32'h0);
    cmp("t1_busy", {31'd0, busy}, 32'd0);
    cmp("t1_done", {31'd0, done}, 32'd0);
    cmp("t1_tmo", {31'd0, tmo_err}, 32'd0);
    cmp("t1_slot", {27'd0, cur_slot}, 32'd0);
    rst = 0;
    @(negedge clk);

    // 2: two slots, ack two cycles after each valid
    start = 1; slot_mask = 32'h0000_0005;
    @(negedge clk); start = 0;
    cmp("t2_count0", {24'd0, count}, 32'h80);
    cmp("t2_sel0", select, 32'h1);
    @(negedge clk);
    @(negedge clk); slot_ack = 1;
    @(negedge clk); slot_ack = 0;
    cmp("t2_count1", {24'd0, count}, 32'h82);
    cmp("t2_sel1", select, 32'h4);
    @(negedge clk);
    @(negedge clk); slot_ack = 1;
    @(negedge clk); slot_ack = 0;
    cmp("t2_done", {31'd0, done}, 32'd1);
    cmp("t2_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    cmp("t2_done_pulse", {31'd0, done}, 32'd0);

    // 3: first and last slot, ack tied high
    start = 1; slot_mask = 32'h8000_0001; slot_ack = 1;
    @(negedge clk); start = 0;
    cmp("t3_count0", {24'd0, count}, 32'h80);
    @(negedge clk);
    cmp("t3_count1", {24'd0, count}, 32'h9F);
    cmp("t3_sel1", select, 32'h8000_0000);
    @(negedge clk); slot_ack = 0;
    cmp("t3_done", {31'd0, done}, 32'd1);
    @(negedge clk);

    // 4: unanswered slot times out
    start = 1; slot_mask = 32'h0000_0002;
    @(negedge clk); start = 0;
    held = 0; seen_done = 0;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      if (slot_valid) held++;
      if (done) seen_done = 1;
      else @(negedge clk);
    end
    cmp("t4_done_seen", {31'd0, seen_done}, 32'd1);
    cmp("t4_held", 32'(held), 32'(TMO));
    cmp("t4_tmo", {31'd0, tmo_err}, 32'd1);
    @(negedge clk);
    start = 1; slot_mask = 32'h0000_0001;
    @(negedge clk); start = 0;
    cmp("t4_tmo_clr", {31'd0, tmo_err}, 32'd0);
    slot_ack = 1;
    @(negedge clk); slot_ack = 0;
    @(negedge clk);

    // 5: empty mask
    start = 1; slot_mask = 32'h0;
    done_cnt = 0; saw_busy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); start = 0;
      if (done) done_cnt++;
      if (busy || slot_valid) saw_busy = 1;
    end
    cmp("t5_done_once", 32'(done_cnt), 32'd1);
    cmp("t5_no_busy", {31'd0, saw_busy}, 32'd0);

    // 6: full mask, start mid-scan ignored, abort with ack on slot 4
    start = 1; slot_mask = 32'hFFFF_FFFF; slot_ack = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    cmp("t6_slot3", {27'd0, cur_slot}, 32'd3);
    @(negedge clk);
    cmp("t6_slot4", {27'd0, cur_slot}, 32'd4);
    abort = 1;
    @(negedge clk); abort = 0; slot_ack = 0;
    cmp("t6_count", {24'd0, count}, 32'h00);
    cmp("t6_busy", {31'd0, busy}, 32'd0);
    cmp("t6_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    cmp("t6_done2", {31'd0, done}, 32'd0);

    // 7: abort keeps tmo_err; mid-scan reset clears it
    start = 1; slot_mask = 32'h0000_0003;
    @(negedge clk); start = 0;
    repeat (TMO) @(negedge clk);
    cmp("t7_slot1", {27'd0, cur_slot}, 32'd1);
    cmp("t7_tmo", {31'd0, tmo_err}, 32'd1);
    abort = 1;
    @(negedge clk); abort = 0;
    cmp("t7_tmo_kept", {31'd0, tmo_err}, 32'd1);
    cmp("t7_idle", {31'd0, busy}, 32'd0);
    start = 1; slot_mask = 32'h0000_0003;
    @(negedge clk); start = 0;
    repeat (TMO) @(negedge clk);
    cmp("t7_tmo2", {31'd0, tmo_err}, 32'd1);
    rst = 1;
    @(negedge clk); rst = 0;
    cmp("t7_rst_tmo", {31'd0, tmo_err}, 32'd0);
    cmp("t7_rst_valid", {31'd0, slot_valid}, 32'd0);
    cmp("t7_rst_count", {24'd0, count}, 32'h00);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
